// File: rtl/conv_frame_sequencer.sv
// conv_frame_sequencer
//   Front-end sequencer for the stride-1, no-padding 3x3 line-buffer
//   convolution path. Accepts a raster pixel stream, tracks column/row,
//   drives the line buffer strobes and flags complete 3x3 windows.
//
// Ports:
//   clk, rst        clock; asynchronous active-low reset
//   start           begin a frame (sampled in IDLE only)
//   abort           synchronous abandon of the current frame
//   in_valid/in_data/in_ready   upstream pixel handshake
//   out_ready       downstream (MAC) can accept a window this cycle
//   lb_valid/lb_data/lb_sof/lb_eof   line-buffer shift strobe, pixel, frame marks
//   lb_flush        one-cycle clear-all-cells pulse
//   win_valid/win_col/win_row   window complete + bottom-right coordinates
//   busy            state is not IDLE
//   frame_done      one-cycle end-of-frame pulse
module conv_frame_sequencer #(
  parameter int IMG_W  = 6,
  parameter int IMG_H  = 6,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  input  logic              out_ready,
  output logic              lb_valid,
  output logic [DATA_W-1:0] lb_data,
  output logic              lb_sof,
  output logic              lb_eof,
  output logic              lb_flush,
  output logic              win_valid,
  output logic [10:0]       win_col,
  output logic [10:0]       win_row,
  output logic              busy,
  output logic              frame_done
);

  localparam logic [10:0] LAST_COL = 11'(IMG_W - 1);
  localparam logic [10:0] LAST_ROW = 11'(IMG_H - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_t;

  state_t      state, state_nx;
  logic [1:0]  fcnt, fcnt_nx;
  logic [10:0] col, row, col_nx, row_nx;
  logic [10:0] s1_col, s1_row;
  logic        accept, at_first, at_last, abort_act, done_nx, flush_nx;

  assign in_ready  = (state == RUN) & out_ready;
  assign busy      = (state != IDLE);
  assign accept    = in_valid & in_ready;
  assign abort_act = abort & (state != IDLE);
  assign at_first  = (col == '0) && (row == '0);
  assign at_last   = (col == LAST_COL) && (row == LAST_ROW);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      fcnt  <= '0;
      col   <= '0;
      row   <= '0;
    end else begin
      state <= state_nx;
      fcnt  <= fcnt_nx;
      col   <= col_nx;
      row   <= row_nx;
    end
  end

  always_comb begin
    state_nx = state;
    fcnt_nx  = fcnt;
    col_nx   = col;
    row_nx   = row;
    done_nx  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nx = RUN;
          col_nx   = '0;
          row_nx   = '0;
        end
      end
      RUN: begin
        if (accept) begin
          if (col == LAST_COL) begin
            col_nx = '0;
            row_nx = row + 11'd1;
          end else begin
            col_nx = col + 11'd1;
          end
          if (at_last) begin
            state_nx = FLUSH;
            fcnt_nx  = '0;
          end
        end
      end
      FLUSH: begin
        if (fcnt == 2'd1) begin
          state_nx = IDLE;
          fcnt_nx  = '0;
          done_nx  = 1'b1;
        end else begin
          fcnt_nx = fcnt + 2'd1;
        end
      end
      default: state_nx = IDLE;
    endcase
    // Abort overrides everything, including a same-cycle accept or frame end.
    if (abort_act) begin
      state_nx = IDLE;
      fcnt_nx  = '0;
      col_nx   = '0;
      row_nx   = '0;
      done_nx  = 1'b0;
    end
    flush_nx = done_nx | abort_act;
  end

  // Two-stage pipeline: stage 1 feeds the line buffer, stage 2 flags windows.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lb_valid   <= 1'b0;
      lb_data    <= '0;
      lb_sof     <= 1'b0;
      lb_eof     <= 1'b0;
      s1_col     <= '0;
      s1_row     <= '0;
      win_valid  <= 1'b0;
      win_col    <= '0;
      win_row    <= '0;
      lb_flush   <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      lb_flush   <= flush_nx;
      frame_done <= done_nx;
      if (abort_act) begin
        lb_valid  <= 1'b0;
        lb_data   <= '0;
        lb_sof    <= 1'b0;
        lb_eof    <= 1'b0;
        s1_col    <= '0;
        s1_row    <= '0;
        win_valid <= 1'b0;
        win_col   <= '0;
        win_row   <= '0;
      end else begin
        lb_valid <= accept;
        lb_sof   <= accept & at_first;
        lb_eof   <= accept & at_last;
        if (accept) begin
          lb_data <= in_data;
          s1_col  <= col;
          s1_row  <= row;
        end
        win_valid <= lb_valid && (s1_row >= 11'd2) && (s1_col >= 11'd2);
        if (lb_valid) begin
          win_col <= s1_col;
          win_row <= s1_row;
        end
      end
    end
  end

endmodule
